prueba_s7_button_pio: RTL and testbench
=======================================

# prueba_s7_button_pio

Avalon-MM input PIO slave that samples an 8-bit external input bus (push-buttons/switches). It synchronizes and debounces each bit, and latches edges into a sticky capture register. It raises a level interrupt when any captured edge is unmasked. It is the read-side counterpart of the LED output PIO on the same system interconnect, with an identical address and bus shape.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronized bit must differ from its debounced value before the debounced value updates; legal range 1..65535.
- EDGE_TYPE, 0, edges that set capture bits: 0 = rising, 1 = falling, 2 = any.
- clk  input  1  single system clock; all state is rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  2  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; a write is chipselect && !write_n.
- writedata  input  32  write data; only [7:0] is used.
- in_port  input  8  raw asynchronous external inputs.
- readdata  output  32  read data; zero-latency combinational mux, bits [31:8] = 0.
- irq  output  1  level interrupt, active high.

## Operation
- Register map, by address:
  - 0 = DATA: read-only debounced value; writes ignored.
  - 1 = reserved: reads 0; writes ignored.
  - 2 = IRQMASK: read/write [7:0].
  - 3 = EDGECAP: read [7:0]; a write clears the bits where writedata is 1 (write-1-to-clear).
- Synchronizer: two flops per bit (sync1, sync2), no reset-release special case.
- Debounce, per bit i, with its own counter of width clog2(DEBOUNCE_CYCLES+1):
  - If sync2[i] == deb[i], the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, deb[i] <= sync2[i] and the counter clears in the same cycle.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes deb[i].
- Edge detect: deb_d <= deb each cycle.
  - rise = deb & ~deb_d
  - fall = ~deb & deb_d
  - The edge vector is selected by EDGE_TYPE.
- EDGECAP bit i sets on edge[i] and holds until cleared by software.
- Set and clear of the same bit in the same cycle: set wins, so the bit stays 1.
- irq = |(EDGECAP & IRQMASK). It is combinational from registered state and has no extra flop.
- Reset values:
  - sync1, sync2, deb, deb_d, all counters, IRQMASK and EDGECAP are 0.
  - readdata = 0 and irq = 0 while reset_n = 0.
- Reset asserted mid-debounce or with pending captures clears everything immediately, asynchronously.
- On release, an input already high produces one rising edge once debounced. That edge is captured as normal.
- The block has no wait states and no read side effects. Reading EDGECAP does not clear it.

## Timing
- in_port change to sync2: 2 cycles.
- sync2 stable differing to deb update: DEBOUNCE_CYCLES cycles.
- Total in_port to DATA readable: 2 + DEBOUNCE_CYCLES cycles.
- deb change to EDGECAP set: 1 cycle, so EDGECAP is visible at 3 + DEBOUNCE_CYCLES cycles. irq asserts in the same cycle if the bit is masked on.
- IRQMASK and EDGECAP writes take effect at the next rising clk edge. irq reflects them in that cycle.
- readdata is valid in the same cycle as address/chipselect, with read latency 0.

## Test plan
- Reset: hold reset_n = 0 with in_port = 8'hFF.
  - During reset: readdata = 0 and irq = 0 at every address.
  - After release, with DEBOUNCE_CYCLES = 4: DATA reads 8'hFF at cycle 6, and EDGECAP reads 8'hFF at cycle 7 (EDGE_TYPE = 0).
- Debounce filter, DEBOUNCE_CYCLES = 4:
  - A 3-cycle pulse on in_port[0] leaves DATA = 0 and EDGECAP = 0.
  - A 4-cycle-stable high sets DATA[0] exactly 6 cycles after the in_port edge.
- Interrupt: IRQMASK = 8'h05 and a rising edge on bit 2.
  - irq = 1 and EDGECAP = 8'h04.
  - An edge on bit 1 alone sets EDGECAP[1] with irq = 0.
- Write-1-to-clear: EDGECAP = 8'h0F, write 8'h05 to address 3.
  - EDGECAP = 8'h0A next cycle.
  - With IRQMASK = 8'h05, irq drops to 0.
- Set/clear collision: write 8'h01 to address 3 in the same cycle bit 0's edge registers. EDGECAP[0] = 1 afterwards.
- EDGE_TYPE = 1 and EDGE_TYPE = 2: toggle bit 7 high then low.
  - Falling mode: capture only after the high-to-low transition.
  - Any mode: capture after both transitions.
  - Address 1 reads 0 and address 0 is unaffected by writes throughout.

Source files
------------

// File: rtl/prueba_s7_button_pio.sv
`default_nettype none
// ============================================================================
//  Module   : prueba_s7_button_pio
//  Purpose  : Avalon-MM input PIO. Synchronizes and debounces an 8-bit input
//             bus, latches selected edges into a sticky W1C capture register
//             and raises a level irq for unmasked captured edges.
//  Revision : 1.0 - initial release
// ============================================================================
module prueba_s7_button_pio #(
  parameter int DEBOUNCE_CYCLES = 16,  // 1..65535
  parameter int EDGE_TYPE       = 0    // 0 rising, 1 falling, 2 any
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic [7:0]  in_port,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int                c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] c_ADDR_DATA = 2'd0;
  localparam logic [1:0] c_ADDR_MASK = 2'd2;
  localparam logic [1:0] c_ADDR_ECAP = 2'd3;

  logic [7:0] sync1_q;
  logic [7:0] sync2_q;
  logic [7:0] w_deb;
  logic [7:0] deb_prev_q;
  logic [7:0] mask_q;
  logic [7:0] mask_d;
  logic [7:0] ecap_q;
  logic [7:0] ecap_d;
  logic [7:0] w_edge;
  logic       w_wr;

  // Upper write-data bits carry no register content.
  logic       w_unused_wdata;
  assign w_unused_wdata = ^writedata[31:8];

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: the debounced value follows the synchronized bit only
  // after it has differed for DEBOUNCE_CYCLES consecutive cycles.
  for (genvar i = 0; i < 8; i++) begin : g_deb
    logic [c_CNT_W-1:0] cnt_q;
    logic               deb_q;

    // Count consecutive disagreement cycles; commit on the last one.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else if (sync2_q[i] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == c_CNT_LAST) begin
        cnt_q <= '0;
        deb_q <= sync2_q[i];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign w_deb[i] = deb_q;
  end

  // Delayed copy of the debounced bus for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) deb_prev_q <= 8'h00;
    else          deb_prev_q <= w_deb;
  end

  // Edge vector selected by the build-time edge mode.
  always_comb begin
    w_edge = w_deb ^ deb_prev_q;
    case (EDGE_TYPE)
      0:       w_edge = w_deb & ~deb_prev_q;
      1:       w_edge = ~w_deb & deb_prev_q;
      default: w_edge = w_deb ^ deb_prev_q;
    endcase
  end

  assign w_wr = chipselect && !write_n;

  // Next-state for IRQMASK and EDGECAP; a new edge wins over a W1C clear.
  always_comb begin
    mask_d = mask_q;
    ecap_d = ecap_q;
    if (w_wr && (address == c_ADDR_MASK)) mask_d = writedata[7:0];
    if (w_wr && (address == c_ADDR_ECAP)) ecap_d = ecap_q & ~writedata[7:0];
    ecap_d = ecap_d | w_edge;
  end

  // Software-visible registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= 8'h00;
      ecap_q <= 8'h00;
    end else begin
      mask_q <= mask_d;
      ecap_q <= ecap_d;
    end
  end

  // Zero-latency read mux; all sources are zero while in reset.
  always_comb begin
    readdata = 32'h0;
    case (address)
      c_ADDR_DATA: readdata = {24'h0, w_deb};
      c_ADDR_MASK: readdata = {24'h0, mask_q};
      c_ADDR_ECAP: readdata = {24'h0, ecap_q};
      default:     readdata = 32'h0;
    endcase
  end

  assign irq = |(ecap_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_prueba_s7_button_pio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prueba_s7_button_pio
//  Purpose  : Directed self-checking bench. Three instances (rising, falling,
//             any-edge) share one bus and input stimulus; DEBOUNCE_CYCLES = 4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prueba_s7_button_pio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [7:0]  in_port = 8'hFF;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int n_chk  = 0;
  int n_pass = 0;

  prueba_s7_button_pio #(.DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));

  prueba_s7_button_pio #(.DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u_dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1));

  prueba_s7_button_pio #(.DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  // Advance past n rising edges, landing 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Select a register for reading and let the combinational mux settle.
  task automatic sel(input logic [1:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
  endtask

  // Single-cycle bus write spanning exactly one rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    write_n    = 1'b1;
    chipselect = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with all inputs high: everything reads zero.
    tick(3);
    for (int a = 0; a < 4; a++) begin
      sel(2'(a));
      chk($sformatf("rst_rd_a%0d", a), rd0, 32'h0);
      chk($sformatf("rst_irq_a%0d", a), {31'h0, irq0}, 32'h0);
    end

    // Release: DATA at cycle 6, EDGECAP at cycle 7.
    reset_n = 1'b1;
    tick(5);  sel(2'd0); chk("rel_data_c5", rd0, 32'h00);
    tick(1);  sel(2'd0); chk("rel_data_c6", rd0, 32'hFF);
              sel(2'd3); chk("rel_cap_c6", rd0, 32'h00);
    tick(1);  sel(2'd3); chk("rel_cap_c7", rd0, 32'hFF);
              chk("rel_cap_fall", rd1, 32'h00);
              chk("rel_cap_any", rd2, 32'hFF);
    chk("rel_irq_masked", {31'h0, irq0}, 32'h0);

    // Drop all inputs, clear captures.
    wr(2'd3, 32'hFF);
    in_port = 8'h00;
    tick(7);
    sel(2'd0); chk("low_data", rd0, 32'h00);
    sel(2'd3); chk("low_cap_rise", rd0, 32'h00);
               chk("low_cap_fall", rd1, 32'hFF);
    wr(2'd3, 32'hFF);

    // 3-cycle glitch on bit 0 is filtered.
    in_port = 8'h01;
    tick(3);
    in_port = 8'h00;
    tick(10);
    sel(2'd0); chk("glitch_data", rd0, 32'h00);
    sel(2'd3); chk("glitch_cap", rd0, 32'h00);

    // Stable high on bit 0: DATA exactly 6 cycles after the input edge.
    in_port = 8'h01;
    tick(5);  sel(2'd0); chk("stable_data_c5", rd0, 32'h00);
    tick(1);  sel(2'd0); chk("stable_data_c6", rd0, 32'h01);
    tick(1);  sel(2'd3); chk("stable_cap_c7", rd0, 32'h01);
    wr(2'd3, 32'hFF);

    // Interrupt masking.
    wr(2'd2, 32'h05);
    sel(2'd2); chk("mask_rd", rd0, 32'h05);
    in_port = 8'h05;
    tick(7);
    sel(2'd3); chk("irq_cap_b2", rd0, 32'h04);
    chk("irq_b2_on", {31'h0, irq0}, 32'h1);
    wr(2'd3, 32'hFF);
    chk("irq_after_clr", {31'h0, irq0}, 32'h0);
    in_port = 8'h07;
    tick(7);
    sel(2'd3); chk("irq_cap_b1", rd0, 32'h02);
    chk("irq_b1_off", {31'h0, irq0}, 32'h0);

    // Build EDGECAP = 0F then write-1-to-clear 05.
    in_port = 8'h0A;
    tick(7);
    in_port = 8'h0F;
    tick(7);
    sel(2'd3); chk("w1c_pre", rd0, 32'h0F);
    chk("w1c_irq_pre", {31'h0, irq0}, 32'h1);
    wr(2'd3, 32'h05);
    sel(2'd3); chk("w1c_post", rd0, 32'h0A);
    chk("w1c_irq_post", {31'h0, irq0}, 32'h0);

    // Set/clear collision on bit 0: the edge wins.
    in_port = 8'h0E;
    tick(7);
    wr(2'd3, 32'hFF);
    sel(2'd3); chk("coll_clear", rd0, 32'h00);
    in_port = 8'h0F;
    tick(6);
    sel(2'd3); chk("coll_pre", rd0, 32'h00);
    wr(2'd3, 32'h01);
    sel(2'd3); chk("coll_post", rd0, 32'h01);

    // Bit 7 high then low across the three edge modes.
    wr(2'd3, 32'hFF);
    in_port = 8'h8F;
    tick(7);
    sel(2'd3);
    chk("b7r_rise", rd0, 32'h80);
    chk("b7r_fall", rd1, 32'h00);
    chk("b7r_any", rd2, 32'h80);
    wr(2'd3, 32'hFF);
    in_port = 8'h0F;
    tick(7);
    sel(2'd3);
    chk("b7f_rise", rd0, 32'h00);
    chk("b7f_fall", rd1, 32'h80);
    chk("b7f_any", rd2, 32'h80);

    // Reserved and DATA addresses ignore writes.
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd0, 32'h0000_0055);
    sel(2'd1); chk("rsvd_rd", rd0, 32'h0);
    sel(2'd0); chk("data_wr_ignored", rd0, 32'h0F);
               chk("data_wr_ignored_any", rd2, 32'h0F);
    sel(2'd2); chk("mask_kept", rd0, 32'h05);

    // Asynchronous reset mid-debounce with pending captures.
    in_port = 8'h00;
    tick(4);
    reset_n = 1'b0;
    #1;
    sel(2'd3); chk("arst_cap_fall", rd1, 32'h00);
               chk("arst_cap_any", rd2, 32'h00);
    sel(2'd2); chk("arst_mask", rd0, 32'h00);
    sel(2'd0); chk("arst_data", rd0, 32'h00);
    tick(1);
    reset_n = 1'b1;
    tick(8);
    sel(2'd0); chk("post_arst_data", rd2, 32'h00);
    sel(2'd3); chk("post_arst_cap", rd2, 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
